// File: rtl/ext_dispatch.sv
// rtl/ext_dispatch.sv - RV32M dispatch to shared iterative multiplier/divider units
module ext_dispatch #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        extStart,
  input  logic [2:0]  extFunc3,
  input  logic [31:0] extA,
  input  logic [31:0] extB,
  output logic [31:0] extR,
  output logic        extDone,
  output logic        ext_err,
  output logic        mul_start,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_p,
  input  logic        mul_done,
  output logic        div_start,
  output logic [31:0] div_n,
  output logic [31:0] div_d,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  input  logic        div_done
);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  state_t        state;
  logic [2:0]    func;
  logic [31:0]   a_q, b_q;
  logic          neg;
  logic [TW-1:0] cnt;
  logic [63:0]   res;

  logic        a_signed, b_signed, sa, sb, neg_c, ovf, unit_done;
  logic [31:0] mag_a, mag_b, div_val, div_fix, fix_r;
  logic [63:0] mul_fix;

  // MUL runs through the signed path too; its low word is identical either way.
  always_comb begin
    a_signed  = !(func == 3'b011 || func == 3'b101 || func == 3'b111);
    b_signed  = a_signed && (func != 3'b010);
    sa        = a_signed && a_q[31];
    sb        = b_signed && b_q[31];
    mag_a     = sa ? (~a_q + 32'd1) : a_q;
    mag_b     = sb ? (~b_q + 32'd1) : b_q;
    neg_c     = (func == 3'b110) ? sa : (sa ^ sb);
    ovf       = (func == 3'b100 || func == 3'b110) &&
                (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    unit_done = func[2] ? div_done : mul_done;
    mul_fix   = neg ? (~res + 64'd1) : res;
    div_val   = func[1] ? res[63:32] : res[31:0];
    div_fix   = neg ? (~div_val + 32'd1) : div_val;
    if (func[2])
      fix_r = div_fix;
    else if (func[1:0] == 2'b00)
      fix_r = mul_fix[31:0];
    else
      fix_r = mul_fix[63:32];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      func      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      res       <= '0;
      extR      <= '0;
      extDone   <= 1'b0;
      ext_err   <= 1'b0;
      mul_start <= 1'b0;
      div_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      div_n     <= '0;
      div_d     <= '0;
    end else begin
      case (state)
        IDLE: begin
          extDone <= 1'b0;
          ext_err <= 1'b0;
          if (extStart) begin
            func  <= extFunc3;
            a_q   <= extA;
            b_q   <= extB;
            state <= PREP;
          end
        end
        PREP: begin
          neg <= neg_c;
          cnt <= '0;
          if (func[2] && b_q == 32'd0) begin
            extR    <= func[1] ? a_q : 32'hFFFF_FFFF;
            extDone <= 1'b1;
            state   <= DONE;
          end else if (ovf) begin
            extR    <= func[1] ? 32'd0 : 32'h8000_0000;
            extDone <= 1'b1;
            state   <= DONE;
          end else begin
            if (func[2]) begin
              div_n     <= mag_a;
              div_d     <= mag_b;
              div_start <= 1'b1;
            end else begin
              mul_a     <= mag_a;
              mul_b     <= mag_b;
              mul_start <= 1'b1;
            end
            state <= RUN;
          end
        end
        RUN: begin
          mul_start <= 1'b0;
          div_start <= 1'b0;
          // cnt==0 is the start cycle, where a done pulse cannot belong to this op.
          if (cnt != '0 && unit_done) begin
            res   <= func[2] ? {div_r, div_q} : mul_p;
            state <= FIX;
          end else if (cnt == TW'(TIMEOUT)) begin
            extR    <= '0;
            extDone <= 1'b1;
            ext_err <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          extR    <= fix_r;
          extDone <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          extDone <= 1'b0;
          ext_err <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_dispatch.sv
// tb/tb_ext_dispatch.sv - randomized self-checking bench for ext_dispatch with behavioural unit models
module tb_ext_dispatch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        extStart = 1'b0;
  logic [2:0]  extFunc3 = '0;
  logic [31:0] extA = '0, extB = '0;
  logic [31:0] extR;
  logic        extDone, ext_err;
  logic        mul_start, div_start;
  logic [31:0] mul_a, mul_b, div_n, div_d;
  logic [63:0] mul_p = '0;
  logic        mul_done = 1'b0;
  logic [31:0] div_q = '0, div_r = '0;
  logic        div_done = 1'b0;

  int total = 0;
  int bad = 0;
  int lat = 1;
  bit div_hang = 0;
  int mrem = 0, drem = 0;
  logic [31:0] last_ma, last_mb;

  ext_dispatch #(.TIMEOUT(64), .TW(7)) dut (
    .clk(clk), .rst(rst), .extStart(extStart), .extFunc3(extFunc3),
    .extA(extA), .extB(extB), .extR(extR), .extDone(extDone), .ext_err(ext_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .mul_done(mul_done),
    .div_start(div_start), .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_r(div_r),
    .div_done(div_done)
  );

  always #5 clk = ~clk;

  // Units answer `lat` cycles after their start pulse; the divider can be made to hang.
  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (mul_start) begin
      if (lat == 1) begin mul_done <= 1'b1; mul_p <= {32'b0, mul_a} * {32'b0, mul_b}; end
      else mrem <= lat - 1;
    end else if (mrem > 0) begin
      mrem <= mrem - 1;
      if (mrem == 1) begin mul_done <= 1'b1; mul_p <= {32'b0, mul_a} * {32'b0, mul_b}; end
    end
  end

  always @(posedge clk) begin
    div_done <= 1'b0;
    if (div_start && !div_hang) begin
      if (lat == 1) begin div_done <= 1'b1; div_q <= div_n / div_d; div_r <= div_n % div_d; end
      else drem <= lat - 1;
    end else if (drem > 0) begin
      drem <= drem - 1;
      if (drem == 1) begin div_done <= 1'b1; div_q <= div_n / div_d; div_r <= div_n % div_d; end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_r(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int q;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); return p[63:32]; end
      3'd2: begin p = longint'($signed(a)) * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = int'(a) / int'(b); return q;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = int'(a) % int'(b); return q;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input int exp_cyc, input logic exp_err, input bit extra);
    int cyc = 0, starts = 0, start_cyc = -1, dones = 0;
    bit got = 0;
    @(negedge clk);
    extFunc3 = f; extA = a; extB = b; extStart = 1'b1;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      extStart = extra && (cyc == 3);
      if (mul_start || div_start) begin
        starts++; start_cyc = cyc;
        last_ma = div_start ? div_n : mul_a;
        last_mb = div_start ? div_d : mul_b;
      end
      if (extDone) got = 1;
    end
    extStart = 1'b0;
    check({tag, ".cycle"}, 64'(cyc), 64'(exp_cyc));
    check({tag, ".extR"}, 64'(extR), 64'(exp_r));
    check({tag, ".err"}, 64'(ext_err), 64'(exp_err));
    check({tag, ".starts"}, 64'(starts), (exp_cyc == 2) ? 64'd0 : 64'd1);
    if (starts == 1) check({tag, ".start_cyc"}, 64'(start_cyc), 64'd2);
    @(negedge clk);
    check({tag, ".pulse"}, 64'(extDone), 64'd0);
    if (extra) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (extDone) dones++;
      end
      check({tag, ".no_extra_done"}, 64'(dones), 64'd0);
    end
  endtask

  initial begin
    logic [2:0] f;
    logic [31:0] a, b;
    int r, dones;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst.extR", 64'(extR), 64'd0);
    check("rst.extDone", 64'(extDone), 64'd0);
    check("rst.starts", 64'({mul_start, div_start, ext_err}), 64'd0);
    check("rst.ops", {mul_a | mul_b, div_n | div_d}, 64'd0);

    lat = 3;
    do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 4 + 3, 1'b0, 0);
    check("mul.mul_a", 64'(last_ma), 64'd7);
    check("mul.mul_b", 64'(last_mb), 64'd3);
    lat = 1;
    do_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5, 1'b0, 0);
    lat = 5;
    do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9, 1'b0, 0);
    lat = 2;
    do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 6, 1'b0, 0);
    do_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 6, 1'b0, 0);
    do_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 6, 1'b0, 0);
    do_op("divu", 3'd5, 32'd7, 32'd2, 32'd3, 6, 1'b0, 0);
    do_op("divu0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, 1'b0, 0);
    do_op("rem0", 3'd6, 32'd5, 32'd0, 32'd5, 2, 1'b0, 0);
    do_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1'b0, 0);

    div_hang = 1;
    do_op("timeout", 3'd5, 32'd7, 32'd2, 32'd0, 67, 1'b1, 0);
    div_hang = 0;
    lat = 4;
    do_op("after_to", 3'd5, 32'd100, 32'd7, 32'd14, 8, 1'b0, 0);

    lat = 6;
    do_op("restart", 3'd0, 32'd1234, 32'd5678, 32'd7006652, 10, 1'b0, 1);

    // Reset in RUN: the in-flight divide is dropped and its late done must not leak out.
    lat = 8;
    @(negedge clk);
    extFunc3 = 3'd5; extA = 32'd100; extB = 32'd7; extStart = 1'b1;
    @(negedge clk); extStart = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rrun.extR", 64'(extR), 64'd0);
    check("rrun.flags", 64'({extDone, ext_err, mul_start, div_start}), 64'd0);
    check("rrun.ops", {div_n, div_d}, 64'd0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (extDone) dones++;
    end
    check("rrun.no_done", 64'(dones), 64'd0);

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      r = $urandom_range(0, 9);
      if (r == 0) b = 32'd0;
      else if (r == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (r == 2) b = 32'($urandom_range(1, 5));
      else if (r == 3) a = 32'($urandom_range(0, 20));
      lat = $urandom_range(1, 6);
      do_op($sformatf("rnd%0d_f%0d", i, f), f, a, b, ref_r(f, a, b),
            is_special(f, a, b) ? 2 : 4 + lat, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
